// File: rtl/pcihellocore_display_out.sv
`default_nettype none
// ============================================================================
//  Module      : pcihellocore_display_out
//  Description : Avalon-MM slave output PIO driving LEDs / seven-segment
//                lines. Provides a DATA register with atomic OUTSET/OUTCLR
//                views and a per-bit BLINK mask toggled by an internal
//                prescaler, so outputs can flash without host traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcihellocore_display_out #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
    parameter int          BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             update_strobe
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_OUTSET = 2'd1;
    localparam logic [1:0] c_ADDR_OUTCLR = 2'd2;
    localparam logic [1:0] c_ADDR_BLINK  = 2'd3;

    // Prescaler counter wide enough to hold BLINK_DIV-1 (BLINK_DIV >= 2).
    localparam int c_CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(BLINK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    localparam logic [WIDTH-1:0] c_RESET_DATA = RESET_VALUE[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_mask;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic               r_blink_phase;
    logic [31:0]        r_readdata;
    logic               r_update_strobe;

    logic               w_wr;
    logic               w_wr_blink;
    logic [WIDTH-1:0]   w_wd;
    logic [WIDTH-1:0]   w_data_nxt;
    logic [31:0]        w_data_ext;
    logic [31:0]        w_mask_ext;
    logic [31:0]        w_rd_mux;

    // A write is accepted whenever the slave is selected with write_n low.
    assign w_wr       = chipselect & ~write_n;
    assign w_wr_blink = w_wr & (address == c_ADDR_BLINK);
    assign w_wd       = writedata[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Width handling: drop writedata bits above WIDTH, zero-extend reads
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 32) begin : g_narrow
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
            assign w_data_ext  = {{(32-WIDTH){1'b0}}, r_data};
            assign w_mask_ext  = {{(32-WIDTH){1'b0}}, r_mask};
        end else begin : g_full
            assign w_data_ext = r_data;
            assign w_mask_ext = r_mask;
        end
    endgenerate

    // Next DATA value: load, bitwise set, or bitwise clear depending on view.
    always_comb begin
        w_data_nxt = r_data;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:   w_data_nxt = w_wd;
                c_ADDR_OUTSET: w_data_nxt = r_data | w_wd;
                c_ADDR_OUTCLR: w_data_nxt = r_data & ~w_wd;
                default:       w_data_nxt = r_data;
            endcase
        end
    end

    // DATA register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= c_RESET_DATA;
        end else begin
            r_data <= w_data_nxt;
        end
    end

    // BLINK mask register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_wr_blink) begin
            r_mask <= w_wd;
        end
    end

    // Blink prescaler; a BLINK write restarts the period at phase 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt     <= c_CNT_ZERO;
            r_blink_phase <= 1'b0;
        end else if (w_wr_blink) begin
            r_div_cnt     <= c_CNT_ZERO;
            r_blink_phase <= 1'b0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt     <= c_CNT_ZERO;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_div_cnt     <= r_div_cnt + c_CNT_ONE;
        end
    end

    // Read mux; write-only views read back as zero.
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        case (address)
            c_ADDR_DATA:  w_rd_mux = w_data_ext;
            c_ADDR_BLINK: w_rd_mux = w_mask_ext;
            default:      w_rd_mux = 32'h0000_0000;
        endcase
    end

    // Registered read data, sampled every cycle independent of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0000_0000;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    // One-cycle pulse following every accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_update_strobe <= 1'b0;
        end else begin
            r_update_strobe <= w_wr;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: purely from registers, so the bus cannot glitch out_port
    // ------------------------------------------------------------------------
    assign out_port      = r_data ^ (r_mask & {WIDTH{r_blink_phase}});
    assign readdata      = r_readdata;
    assign update_strobe = r_update_strobe;

endmodule
`default_nettype wire

// File: tb/tb_pcihellocore_display_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcihellocore_display_out
//  Description : Directed self-checking bench for pcihellocore_display_out
//                (WIDTH=8, BLINK_DIV=4; second instance with RESET_VALUE=0x5A).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcihellocore_display_out;

    localparam int c_WIDTH = 8;
    localparam int c_DIV   = 4;

    logic              clk;
    logic              reset_n;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [c_WIDTH-1:0] out_port;
    logic              update_strobe;

    logic [31:0]       readdata2;
    logic [c_WIDTH-1:0] out_port2;
    logic              update_strobe2;

    int n_cmp;
    int n_err;

    pcihellocore_display_out #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE (32'h0000_0000),
        .BLINK_DIV   (c_DIV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .out_port      (out_port),
        .update_strobe (update_strobe)
    );

    // Second instance only checks the non-zero reset value; it is never written.
    pcihellocore_display_out #(
        .WIDTH       (c_WIDTH),
        .RESET_VALUE (32'h0000_005A),
        .BLINK_DIV   (c_DIV)
    ) dut_rv (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (1'b0),
        .write_n       (1'b1),
        .writedata     (writedata),
        .readdata      (readdata2),
        .out_port      (out_port2),
        .update_strobe (update_strobe2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a write at the current negedge, then advance one cycle.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
    endtask

    // Idle bus with a given read address, advance one cycle.
    task automatic bus_idle(input logic [1:0] a);
        address    = a;
        writedata  = 32'h0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] exp_blink;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check("rst_out",     {24'h0, out_port},  32'h00);
        check("rst_out_rv",  {24'h0, out_port2}, 32'h5A);
        check("rst_strobe",  {31'h0, update_strobe}, 32'h0);
        reset_n = 1'b1;
        bus_idle(2'd0);
        check("rd0_rst",     readdata,  32'h0);
        check("rd0_rst_rv",  readdata2, 32'h5A);
        bus_idle(2'd3);
        check("rd3_rst",     readdata,  32'h0);
        check("strobe_idle", {31'h0, update_strobe}, 32'h0);

        // ---------------- DATA / OUTSET / OUTCLR back-to-back ----------------
        bus_wr(2'd0, 32'h0F);
        check("data_0f",     {24'h0, out_port}, 32'h0F);
        check("strobe_w1",   {31'h0, update_strobe}, 32'h1);
        bus_wr(2'd1, 32'hF0);
        check("outset_ff",   {24'h0, out_port}, 32'hFF);
        check("strobe_w2",   {31'h0, update_strobe}, 32'h1);
        bus_wr(2'd2, 32'h3C);
        check("outclr_c3",   {24'h0, out_port}, 32'hC3);
        check("strobe_w3",   {31'h0, update_strobe}, 32'h1);
        bus_idle(2'd1);
        check("strobe_end",  {31'h0, update_strobe}, 32'h0);
        check("rd1_zero",    readdata, 32'h0);
        bus_idle(2'd2);
        check("rd2_zero",    readdata, 32'h0);
        bus_idle(2'd0);
        check("rd0_c3",      readdata, 32'hC3);

        // OUTSET with zero data still strobes and leaves DATA alone
        bus_wr(2'd1, 32'h00);
        check("outset0_out", {24'h0, out_port}, 32'hC3);
        check("outset0_stb", {31'h0, update_strobe}, 32'h1);

        // ---------------- width truncation ----------------
        bus_wr(2'd0, 32'h1FF);
        check("trunc_out",   {24'h0, out_port}, 32'hFF);
        bus_idle(2'd0);
        bus_idle(2'd0);
        check("trunc_rd",    readdata, 32'h0000_00FF);

        // ---------------- ignored writes ----------------
        address = 2'd0; writedata = 32'hAA; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk);
        check("cs0_out",     {24'h0, out_port}, 32'hFF);
        check("cs0_strobe",  {31'h0, update_strobe}, 32'h0);
        address = 2'd2; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        check("wn1_out",     {24'h0, out_port}, 32'hFF);
        check("wn1_strobe",  {31'h0, update_strobe}, 32'h0);

        // ---------------- blink ----------------
        bus_wr(2'd0, 32'h00);
        bus_wr(2'd3, 32'h81);
        // first post-write negedge already reached inside bus_wr
        for (int i = 0; i < 12; i++) begin
            exp_blink = (i >= 4 && i < 8) ? 8'h81 : 8'h00;
            check($sformatf("blink_%0d", i), {24'h0, out_port}, {24'h0, exp_blink});
            bus_idle(2'd3);
        end
        check("rd3_mask",    readdata, 32'h81);
        // now one cycle into a new phase-1 period; go one more, then rewrite
        check("pre_rw",      {24'h0, out_port}, 32'h81);
        bus_idle(2'd3);
        check("pre_rw2",     {24'h0, out_port}, 32'h81);
        bus_wr(2'd3, 32'h81);
        for (int i = 0; i < 5; i++) begin
            exp_blink = (i == 4) ? 8'h81 : 8'h00;
            check($sformatf("rewr_%0d", i), {24'h0, out_port}, {24'h0, exp_blink});
            if (i < 4) bus_idle(2'd3);
        end

        // DATA under an active phase-1 mask is inverted on masked bits
        bus_wr(2'd0, 32'h3C);
        check("blink_xor",   {24'h0, out_port}, 32'hBD);
        bus_idle(2'd3);
        check("rd3_pre_rst", readdata, 32'h81);
        check("xor_hold",    {24'h0, out_port}, 32'hBD);

        // ---------------- asynchronous reset between edges ----------------
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out",    {24'h0, out_port},  32'h00);
        check("arst_out_rv", {24'h0, out_port2}, 32'h5A);
        check("arst_rd",     readdata, 32'h0);
        check("arst_strobe", {31'h0, update_strobe}, 32'h0);
        // a write held during reset must be lost
        address = 2'd0; writedata = 32'h77; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_idle(2'd0);
        check("rst_wr_lost", {24'h0, out_port}, 32'h00);
        check("rst_wr_rd0",  readdata, 32'h00);
        check("rst_wr_stb",  {31'h0, update_strobe}, 32'h0);
        bus_idle(2'd3);
        check("rst_mask_rd", readdata, 32'h00);
        for (int i = 0; i < 6; i++) bus_idle(2'd3);
        check("rst_noblink", {24'h0, out_port}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
